i2s_tx: RTL and testbench
=========================

# i2s_tx

Parametrised I2S/left-justified audio transmitter with an input sample FIFO. It takes stereo frames from an upstream valid/ready source and serialises them onto MCK/SCK/LRCK/SD for the codec DAC. Sample width, slot width, bit-clock ratio, FIFO depth and framing mode are configurable. Underruns are flagged and never stall the serial clocks.

## Interface
- DATA_WIDTH, 24: sample bits per channel, 8..SLOT_WIDTH.
- SLOT_WIDTH, 32: SCK periods per channel slot, 8..32.
- SCK_DIV, 8: clkin cycles per SCK period, even, ≥2.
- FIFO_DEPTH, 4: frames buffered, power of 2, ≥2.
- MODE, 0: 0 = I2S (one-bit delay), 1 = left-justified.
- clkin  in  1  system/master clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  serialiser enable; FIFO accepts writes regardless.
- s_data  in  2*DATA_WIDTH  frame: [2*DW-1:DW] left, [DW-1:0] right, MSB-first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- underrun  out  1  sticky: a frame start found the FIFO empty.
- underrun_clr  in  1  clears underrun.
- mck  out  1  copy of clkin via vendor DDR output cell (ICE40 SB_IO, SPARTAN7 ODDR).
- sck, lrck, sd  out  1  serial bus, all registered.

## Operation
- FIFO: push when s_valid && s_ready; pop only at frame start. s_ready = (fifo_level != FIFO_DEPTH), combinational from level. Push and pop in the same cycle leave the level unchanged.
- A frame has FRAME = 2*SLOT_WIDTH*SCK_DIV clkin cycles and 2*SLOT_WIDTH bit periods. Bit periods 0..SLOT_WIDTH-1 are the left slot (lrck=0); the rest are the right slot (lrck=1).
- Within a bit period, sck is low for the first SCK_DIV/2 cycles and high for the rest. lrck and sd change only at sck falling edges (bit-period start).
- Frame start: one cycle before bit period 0. If the FIFO is non-empty, pop into a shadow register. If it is empty, load zeros and set underrun.
- LJ stream: slot bit b carries sample[DW-1-b] for b < DW, else 0.
- MODE=1 drives the LJ stream on sd. MODE=0 drives the LJ stream delayed by exactly one bit period, with lrck unchanged. The last LSB of a slot may therefore spill into bit 0 of the next slot when DW = SLOT_WIDTH.
- en low: counters held at 0, and sck, lrck, sd forced to 0. The delay bit is cleared, so no stale bit leaks. en rising starts a new frame; the first bit period begins 2 cycles after en is sampled high.
- underrun_clr has priority over a same-cycle set. underrun stays 1 until cleared.
- Push when a pop finds the FIFO empty in the same cycle: the pop loads zeros (underrun), and the pushed frame is served next frame.

## Timing
- Reset values: sck=0, lrck=0, sd=0, underrun=0, fifo_level=0, s_ready=1, counters 0, shadow and delay registers 0.
- Reset mid-frame aborts immediately and the FIFO is emptied. After release with en=1, the frame restarts from bit period 0.
- Latency from push into an empty FIFO (en running) to the MSB on sd:
  - The pushed frame waits for the next frame start.
  - MSB appears in bit period 0 (MODE=1) or bit period 1 (MODE=0) of that frame.
- Pop-to-sd: the shadow register is loaded at frame start; the first sd bit is registered at bit-period-0 start.
- Counter wraps at FRAME-1 to 0 with no idle cycle between frames.
- Defaults give FRAME = 512 clkin cycles and SCK = clkin/8.

## Test plan
- Reset, en=1, push L=0xA5A5A5 R=0x5A5A5A (defaults) -> lrck low 256 cycles / high 256. sd carries the MSB of L in bit period 1, the 24 bits then 7 zeros, and R the same way.
- MODE=1, DW=16, SLOT=16, SCK_DIV=2, push L=0x8001 R=0x7FFE -> sd=1 at bit 0 and bit 15, then 0x7FFE bits; lrck toggles every 32 cycles.
- MODE=0, DW=SLOT=16, L=0x0001 R=0x8000 -> the L LSB appears at right-slot bit 0, coinciding with the R MSB position shift. Bit 0 of the next left slot = R LSB = 0.
- Push 5 frames into a depth-4 FIFO with en=0 -> s_ready=0 after 4, fifo_level=4, 5th not accepted. en=1 -> level drops by 1 per frame start.
- Empty FIFO with en=1 -> sd all 0, underrun=1 at first frame start. Assert underrun_clr together with a new empty frame start -> underrun stays 0 that cycle, set again next start.
- Assert rst_n low mid-frame at bit period 10 -> all outputs 0 within the same cycle, level=0. Release -> resumes from bit 0.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S / left-justified stereo transmitter with a small frame FIFO.
// Serial clocks free-run while enabled; an empty FIFO at frame start sends silence and flags underrun.
module i2s_tx #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned SCK_DIV    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                          clkin,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [2*DATA_WIDTH-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic                          mck,
    output logic                          sck,
    output logic                          lrck,
    output logic                          sd
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned FW    = 2 * DATA_WIDTH;
    localparam int unsigned NBITS = 2 * SLOT_WIDTH;
    localparam int unsigned DIVW  = $clog2(SCK_DIV);
    localparam int unsigned BITW  = $clog2(NBITS);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [DIVW-1:0]     div_q, div_d;
    logic [BITW-1:0]     bit_q, bit_d;
    logic [FW-1:0]       shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                dly_q, dly_d;
    logic                sck_q, sck_d;
    logic                lrck_q, lrck_d;
    logic                sd_q, sd_d;
    logic                underrun_q, underrun_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [FW-1:0]       mem_q [FIFO_DEPTH];

    logic                push, pop, frame_end, frame_start, bit_start;
    logic                right_slot, slot_first, lj_bit;
    logic [DATA_WIDTH-1:0] sample;

    assign s_ready     = (level_q != LW'(FIFO_DEPTH));
    assign push        = s_valid && s_ready;
    assign frame_end   = (bit_q == BITW'(NBITS - 1)) && (div_q == DIVW'(SCK_DIV - 1));
    assign frame_start = en && ((state_q == ST_PRIME) || ((state_q == ST_RUN) && frame_end));
    assign pop         = frame_start && (level_q != '0);
    assign bit_start   = (state_q == ST_RUN) && (div_q == '0);
    assign right_slot  = (bit_q >= BITW'(SLOT_WIDTH));
    assign slot_first  = (bit_q == '0) || (bit_q == BITW'(SLOT_WIDTH));
    assign sample      = right_slot ? shadow_q[DATA_WIDTH-1:0] : shadow_q[FW-1:DATA_WIDTH];
    // Slot MSB comes straight from the shadow; later bits shift out of sr, zero-filling past DATA_WIDTH.
    assign lj_bit      = slot_first ? sample[DATA_WIDTH-1] : sr_q[DATA_WIDTH-1];

    // Serialiser sequencing: IDLE -> PRIME (first frame start) -> RUN
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        dly_d   = dly_q;
        sck_d   = 1'b0;
        lrck_d  = 1'b0;
        sd_d    = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: state_d = ST_RUN;
            ST_RUN: begin
                sck_d  = (div_q >= DIVW'(SCK_DIV / 2));
                lrck_d = lrck_q;
                sd_d   = sd_q;
                if (bit_start) begin
                    lrck_d = right_slot;
                    sd_d   = (MODE == 1) ? lj_bit : dly_q;
                    dly_d  = lj_bit;
                    sr_d   = slot_first ? {sample[DATA_WIDTH-2:0], 1'b0}
                                        : {sr_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (div_q == DIVW'(SCK_DIV - 1)) begin
                    div_d = '0;
                    bit_d = frame_end ? '0 : bit_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = '0;
            sr_d    = '0;
            dly_d   = 1'b0;
            sck_d   = 1'b0;
            lrck_d  = 1'b0;
            sd_d    = 1'b0;
        end
    end

    // FIFO bookkeeping, shadow load at frame start, sticky underrun
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        shadow_d   = shadow_q;
        underrun_d = underrun_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (frame_start) begin
            shadow_d = pop ? mem_q[rd_ptr_q] : '0;
            if (!pop) underrun_d = 1'b1;
        end
        if (underrun_clr) underrun_d = 1'b0;
    end

    always_ff @(posedge clkin) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shadow_q   <= '0;
            sr_q       <= '0;
            dly_q      <= 1'b0;
            sck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shadow_q   <= shadow_d;
            sr_q       <= sr_d;
            dly_q      <= dly_d;
            sck_q      <= sck_d;
            lrck_q     <= lrck_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Behavioural stand-in for the vendor DDR output cell (D0=1, D1=0)
    assign mck        = clkin;
    assign sck        = sck_q;
    assign lrck       = lrck_q;
    assign sd         = sd_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default I2S instance plus two 16-bit/16-slot instances (LJ and I2S).
module tb_i2s_tx;
    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    logic        rst_n;
    logic        en0, valid0, clr0, ready0, ur0, mck0, sck0, lrck0, sd0;
    logic [47:0] data0;
    logic [2:0]  level0;
    logic        en1, valid1, clr1;
    logic [31:0] data1;
    logic        ready1, ur1, mck1, sck1, lrck1, sd1;
    logic        ready2, ur2, mck2, sck2, lrck2, sd2;
    logic [2:0]  level1, level2;

    i2s_tx u0 (
        .clkin(clkin), .rst_n(rst_n), .en(en0), .s_data(data0), .s_valid(valid0),
        .s_ready(ready0), .fifo_level(level0), .underrun(ur0), .underrun_clr(clr0),
        .mck(mck0), .sck(sck0), .lrck(lrck0), .sd(sd0)
    );

    i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .SCK_DIV(2), .FIFO_DEPTH(4), .MODE(1)) u1 (
        .clkin(clkin), .rst_n(rst_n), .en(en1), .s_data(data1), .s_valid(valid1),
        .s_ready(ready1), .fifo_level(level1), .underrun(ur1), .underrun_clr(clr1),
        .mck(mck1), .sck(sck1), .lrck(lrck1), .sd(sd1)
    );

    i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .SCK_DIV(2), .FIFO_DEPTH(4), .MODE(0)) u2 (
        .clkin(clkin), .rst_n(rst_n), .en(en1), .s_data(data1), .s_valid(valid1),
        .s_ready(ready2), .fifo_level(level2), .underrun(ur2), .underrun_clr(clr1),
        .mck(mck2), .sck(sck2), .lrck(lrck2), .sd(sd2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after the posedge that brings cyc to tgt
    task automatic goto(input int tgt);
        while (cyc < tgt) @(negedge clkin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [63:0] exp0;
        logic [31:0] w_lj, w_i2s;
        logic [47:0] d;

        rst_n = 1'b0; en0 = 1'b0; valid0 = 1'b0; clr0 = 1'b0; data0 = '0;
        en1 = 1'b0; valid1 = 1'b0; clr1 = 1'b0; data1 = '0;
        repeat (3) @(negedge clkin);

        check("rst sck",   32'(sck0), 32'd0);
        check("rst lrck",  32'(lrck0), 32'd0);
        check("rst sd",    32'(sd0), 32'd0);
        check("rst ur",    32'(ur0), 32'd0);
        check("rst level", 32'(level0), 32'd0);
        check("rst ready", 32'(ready0), 32'd1);
        check("rst mck",   32'(mck0), 32'd0);
        check("rst small", 32'({ready1, ready2, ur1, ur2, mck1, mck2, sck2, level2}),
                           32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));
        rst_n = 1'b1;
        @(negedge clkin);

        // 16-bit instances: frame A L=8001 R=7FFE, frame B L=0001 R=8000
        valid1 = 1'b1; data1 = 32'h8001_7FFE;
        @(negedge clkin);
        data1 = 32'h0001_8000;
        @(negedge clkin);
        valid1 = 1'b0;
        check("small level", 32'({level1, level2}), 32'({3'd2, 3'd2}));
        en1 = 1'b1;
        c = cyc;
        for (int f = 0; f < 2; f++) begin
            // LJ stream = sample bits MSB-first; I2S stream is that shifted one bit later
            w_lj  = (f == 0) ? 32'h8001_7FFE : 32'h0001_8000;
            w_i2s = (f == 0) ? 32'h4000_BFFF : 32'h0000_C000;
            for (int b = 0; b < 32; b++) begin
                goto(c + 3 + f * 64 + 2 * b);
                check($sformatf("lj sck lo f%0d b%0d", f, b), 32'({sck1, sck2}), 32'd0);
                if (b == 0)
                    check($sformatf("lj level f%0d", f), 32'(level1), 32'(1 - f));
                goto(c + 3 + f * 64 + 2 * b + 1);
                check($sformatf("lj sck hi f%0d b%0d", f, b), 32'({sck1, sck2}), 32'd3);
                check($sformatf("lj lrck f%0d b%0d", f, b), 32'({lrck1, lrck2}),
                      (b >= 16) ? 32'd3 : 32'd0);
                check($sformatf("lj sd f%0d b%0d", f, b), 32'(sd1), 32'(w_lj[31]));
                check($sformatf("i2s sd f%0d b%0d", f, b), 32'(sd2), 32'(w_i2s[31]));
                w_lj  = w_lj << 1;
                w_i2s = w_i2s << 1;
            end
        end
        goto(c + 3 + 128);
        check("small underrun", 32'({ur1, ur2}), 32'd3);
        check("small sd f2", 32'({sd1, sd2}), 32'd0);
        en1 = 1'b0;
        @(negedge clkin);
        @(negedge clkin);
        check("small en off", 32'({sck1, lrck1, sd1}), 32'd0);

        // Default instance: L=A5A5A5 R=5A5A5A, I2S framing
        data0 = {24'hA5A5A5, 24'h5A5A5A};
        valid0 = 1'b1;
        @(negedge clkin);
        valid0 = 1'b0;
        check("def level push", 32'(level0), 32'd1);
        en0 = 1'b1;
        c = cyc;
        exp0 = {1'b0, 24'hA5A5A5, 7'd0, 1'b0, 24'h5A5A5A, 7'd0};
        for (int b = 0; b < 64; b++) begin
            goto(c + 3 + 8 * b + 2);
            check($sformatf("def sck lo b%0d", b), 32'(sck0), 32'd0);
            if (b == 0)
                check("def pop", 32'({level0, ur0}), 32'({3'd0, 1'b0}));
            goto(c + 3 + 8 * b + 6);
            check($sformatf("def sck hi b%0d", b), 32'(sck0), 32'd1);
            check($sformatf("def lrck b%0d", b), 32'(lrck0), (b >= 32) ? 32'd1 : 32'd0);
            check($sformatf("def sd b%0d", b), 32'(sd0), 32'(exp0[63]));
            exp0 = exp0 << 1;
        end
        goto(c + 3 + 512);
        check("def underrun f1", 32'(ur0), 32'd1);
        check("def sd f1 b0", 32'(sd0), 32'd0);
        goto(c + 3 + 512 + 14);
        check("def sd f1 b1", 32'(sd0), 32'd0);

        goto(c + 1 + 1024);
        check("ur before clr", 32'(ur0), 32'd1);
        clr0 = 1'b1;
        goto(c + 2 + 1024);
        clr0 = 1'b0;
        check("clr beats set", 32'(ur0), 32'd0);
        goto(c + 2 + 1536);
        check("ur set again", 32'(ur0), 32'd1);
        check("lrck before off", 32'(lrck0), 32'd1);
        en0 = 1'b0;
        @(negedge clkin);
        check("def en off", 32'({sck0, lrck0, sd0}), 32'd0);
        clr0 = 1'b1;
        @(negedge clkin);
        clr0 = 1'b0;

        // Overfill a depth-4 FIFO while disabled
        for (int k = 0; k < 5; k++) begin
            d = (k == 0 || k == 4) ? 48'hFFFFFF_000000 :
                (k == 1) ? 48'h7FFFFF_000000 : 48'h0;
            data0 = d;
            valid0 = 1'b1;
            check($sformatf("ovf ready k%0d", k), 32'(ready0), (k < 4) ? 32'd1 : 32'd0);
            @(negedge clkin);
        end
        valid0 = 1'b0;
        check("ovf level", 32'(level0), 32'd4);
        check("ovf ready full", 32'(ready0), 32'd0);
        en0 = 1'b1;
        c = cyc;
        goto(c + 3);
        check("ovf level f0", 32'(level0), 32'd3);
        goto(c + 3 + 14);
        check("ovf sd f0 b1", 32'(sd0), 32'd1);
        goto(c + 3 + 512);
        check("ovf level f1", 32'(level0), 32'd2);
        goto(c + 3 + 512 + 14);
        check("ovf sd f1 b1", 32'(sd0), 32'd0);
        goto(c + 3 + 512 + 86);
        check("pre-rst outs", 32'({sck0, lrck0, sd0}), 32'({1'b1, 1'b0, 1'b1}));

        // Reset at bit period 10 of frame 1
        rst_n = 1'b0;
        #1;
        check("mid rst outs", 32'({sck0, lrck0, sd0}), 32'd0);
        check("mid rst level", 32'({level0, ready0}), 32'({3'd0, 1'b1}));
        @(negedge clkin);
        @(negedge clkin);
        rst_n = 1'b1;
        c = cyc;
        goto(c + 3);
        check("restart b0", 32'({sck0, lrck0, sd0}), 32'd0);
        check("restart ur", 32'(ur0), 32'd1);
        goto(c + 3 + 6);
        check("restart sck", 32'(sck0), 32'd1);
        goto(c + 3 + 255);
        check("restart lrck L", 32'(lrck0), 32'd0);
        goto(c + 3 + 256);
        check("restart lrck R", 32'(lrck0), 32'd1);
        en0 = 1'b0;
        @(negedge clkin);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
